// File: rtl/hamming_scrub_ctrl_if.sv
// RAM-side port of the Hamming(7,4) scrubber: one shared address, read strobe
// with single-cycle read data, and a write strobe carrying the corrected codeword.
interface hamming_scrub_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [6:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [6:0]        mem_wr_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/hamming_scrub_ctrl.sv
// Walks a Hamming(7,4) codeword memory, rewrites single-bit-corrected words and
// keeps a saturating correction count plus the address/syndrome of the latest fix.
module hamming_scrub_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    hamming_scrub_ctrl_if.master    mem,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [CNT_W-1:0]        o_corr_count,
    output logic [ADDR_W-1:0]       o_last_err_addr,
    output logic [2:0]              o_last_syndrome
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_CHECK   = 3'd3,
        S_WRITE   = 3'd4,
        S_ADV     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [6:0]          r_word;
    logic [6:0]          r_wr_data;
    logic [CNT_W-1:0]    r_corr_count;
    logic [ADDR_W-1:0]   r_last_err_addr;
    logic [2:0]          r_last_syndrome;

    logic [2:0]          w_syndrome;
    logic                w_busy;
    logic                w_done;
    logic                w_rd_en;
    logic                w_wr_en;

    // Bit i of the codeword is Hamming position i+1; parity sits at bits 0, 1, 3.
    function automatic logic [2:0] f_syndrome(input logic [6:0] word);
        logic s1, s2, s3;
        s1 = word[0] ^ word[2] ^ word[4] ^ word[6];
        s2 = word[1] ^ word[2] ^ word[5] ^ word[6];
        s3 = word[3] ^ word[4] ^ word[5] ^ word[6];
        return {s3, s2, s1};
    endfunction

    function automatic logic [6:0] f_correct(input logic [6:0] word, input logic [2:0] syn);
        logic [6:0] flip;
        flip = '0;
        if (syn != 3'd0)
            flip[syn - 3'd1] = 1'b1;
        return word ^ flip;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    assign w_syndrome = f_syndrome(r_word);

    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            S_READ:    begin w_busy = 1'b1; w_rd_en = 1'b1; end
            S_CAPTURE: w_busy = 1'b1;
            S_CHECK:   w_busy = 1'b1;
            S_WRITE:   begin w_busy = 1'b1; w_wr_en = 1'b1; end
            S_ADV:     w_busy = 1'b1;
            S_DONE:    w_done = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_READ;
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_CHECK;
            S_CHECK:   w_next = (w_syndrome != 3'd0) ? S_WRITE : S_ADV;
            S_WRITE:   w_next = S_ADV;
            S_ADV:     w_next = (r_addr == LAST_ADDR) ? S_DONE : S_READ;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        // A write already on the bus in WRITE still lands; only the successor changes.
        if (w_busy && i_abort)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_word          <= '0;
            r_wr_data       <= '0;
            r_corr_count    <= '0;
            r_last_err_addr <= '0;
            r_last_syndrome <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr          <= '0;
                        r_corr_count    <= '0;
                        r_last_err_addr <= '0;
                        r_last_syndrome <= '0;
                    end
                end
                S_CAPTURE: r_word <= mem.mem_rd_data;
                S_CHECK: begin
                    if (w_syndrome != 3'd0) begin
                        r_corr_count    <= f_sat_inc(r_corr_count);
                        r_last_err_addr <= r_addr;
                        r_last_syndrome <= w_syndrome;
                        r_wr_data       <= f_correct(r_word, w_syndrome);
                    end
                end
                S_ADV: begin
                    if (w_next == S_READ)
                        r_addr <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_addr    = r_addr;
    assign mem.mem_rd_en   = w_rd_en;
    assign mem.mem_wr_en   = w_wr_en;
    assign mem.mem_wr_data = r_wr_data;

    assign o_busy          = w_busy;
    assign o_done          = w_done;
    assign o_corr_count    = r_corr_count;
    assign o_last_err_addr = r_last_err_addr;
    assign o_last_syndrome = r_last_syndrome;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl: table of full-scan scenarios plus
// hand-written abort, restart/reset and counter-saturation sequences.
module tb_hamming_scrub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;

    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] corr_a;
    logic [1:0] corr_b;
    logic [3:0] lea_a, lea_b;
    logic [2:0] syn_a, syn_b;

    hamming_scrub_ctrl_if #(.ADDR_W(4)) bus_a ();
    hamming_scrub_ctrl_if #(.ADDR_W(4)) bus_b ();

    hamming_scrub_ctrl #(.ADDR_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_abort(abort_a), .mem(bus_a),
        .o_busy(busy_a), .o_done(done_a), .o_corr_count(corr_a),
        .o_last_err_addr(lea_a), .o_last_syndrome(syn_a)
    );

    hamming_scrub_ctrl #(.ADDR_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_abort(abort_b), .mem(bus_b),
        .o_busy(busy_b), .o_done(done_b), .o_corr_count(corr_b),
        .o_last_err_addr(lea_b), .o_last_syndrome(syn_b)
    );

    // Valid Hamming(7,4) codewords for data 0..15, hand-encoded.
    logic [6:0] golden [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    logic [6:0] ram_a [16], ram_b [16], init_a [16], init_b [16];
    logic ld_a = 1'b0, ld_b = 1'b0;

    always @(posedge clk) begin
        if (ld_a) begin
            for (int i = 0; i < 16; i++) ram_a[i] <= init_a[i];
        end else begin
            if (bus_a.mem_rd_en) bus_a.mem_rd_data <= ram_a[bus_a.mem_addr];
            if (bus_a.mem_wr_en) ram_a[bus_a.mem_addr] <= bus_a.mem_wr_data;
        end
    end

    always @(posedge clk) begin
        if (ld_b) begin
            for (int i = 0; i < 16; i++) ram_b[i] <= init_b[i];
        end else begin
            if (bus_b.mem_rd_en) bus_b.mem_rd_data <= ram_b[bus_b.mem_addr];
            if (bus_b.mem_wr_en) ram_b[bus_b.mem_addr] <= bus_b.mem_wr_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus activity monitor for DUT a, sampled on the falling edge.
    logic mon_clr = 1'b0;
    int first_rd, last_rd, done_cyc, rd_cnt, wr_cnt, done_cnt, rd0_cnt, wr_lat_bad;
    always @(negedge clk) begin
        if (mon_clr) begin
            first_rd = -1; last_rd = 0; done_cyc = -1;
            rd_cnt = 0; wr_cnt = 0; done_cnt = 0; rd0_cnt = 0; wr_lat_bad = 0;
        end else begin
            if (bus_a.mem_rd_en) begin
                rd_cnt++;
                last_rd = cyc;
                if (first_rd < 0) first_rd = cyc;
                if (bus_a.mem_addr == 4'd0) rd0_cnt++;
            end
            if (bus_a.mem_wr_en) begin
                wr_cnt++;
                if (cyc - last_rd != 3) wr_lat_bad++;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_a(input logic [15:0][6:0] err);
        for (int i = 0; i < 16; i++) init_a[i] = golden[i] ^ err[i];
        ld_a = 1'b1;
        @(posedge clk);
        #1 ld_a = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    function automatic int ram_a_diff();
        int n = 0;
        for (int i = 0; i < 16; i++) if (ram_a[i] !== golden[i]) n++;
        return n;
    endfunction

    function automatic int ram_b_diff();
        int n = 0;
        for (int i = 0; i < 16; i++) if (ram_b[i] !== golden[i]) n++;
        return n;
    endfunction

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, int'(done_a), 1);
    endtask

    typedef struct {
        logic [15:0][6:0] err;
        int exp_corr;
        int exp_last_addr;
        int exp_last_syn;
        int exp_cycles;
        int exp_writes;
    } scan_vec_t;

    scan_vec_t vecs [4];

    initial begin
        int found;
        // Scan scenarios: error masks with hand-derived statistics and scan length.
        vecs[0].err = '0;
        vecs[0].exp_corr = 0; vecs[0].exp_last_addr = 0; vecs[0].exp_last_syn = 0;
        vecs[0].exp_cycles = 64; vecs[0].exp_writes = 0;
        vecs[1].err = '0; vecs[1].err[5] = 7'h04;
        vecs[1].exp_corr = 1; vecs[1].exp_last_addr = 5; vecs[1].exp_last_syn = 3;
        vecs[1].exp_cycles = 65; vecs[1].exp_writes = 1;
        vecs[2].err = '0;
        for (int i = 0; i < 7; i++) vecs[2].err[i] = 7'(1 << i);
        vecs[2].exp_corr = 7; vecs[2].exp_last_addr = 6; vecs[2].exp_last_syn = 7;
        vecs[2].exp_cycles = 71; vecs[2].exp_writes = 7;
        vecs[3].err = '0; vecs[3].err[0] = 7'h08; vecs[3].err[15] = 7'h40;
        vecs[3].exp_corr = 2; vecs[3].exp_last_addr = 15; vecs[3].exp_last_syn = 7;
        vecs[3].exp_cycles = 66; vecs[3].exp_writes = 2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_corr", int'(corr_a), 0);
        check("rst_last_addr", int'(lea_a), 0);
        check("rst_last_syn", int'(syn_a), 0);
        check("rst_mem_addr", int'(bus_a.mem_addr), 0);
        check("rst_rd_en", int'(bus_a.mem_rd_en), 0);
        check("rst_wr_en", int'(bus_a.mem_wr_en), 0);
        check("rst_wr_data", int'(bus_a.mem_wr_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            load_a(vecs[v].err);
            clear_mon();
            pulse_start_a();
            wait_done_a($sformatf("v%0d", v));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_scan_cycles", v), done_cyc - first_rd, vecs[v].exp_cycles);
            check($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_writes);
            check($sformatf("v%0d_corr", v), int'(corr_a), vecs[v].exp_corr);
            check($sformatf("v%0d_last_addr", v), int'(lea_a), vecs[v].exp_last_addr);
            check($sformatf("v%0d_last_syn", v), int'(syn_a), vecs[v].exp_last_syn);
            check($sformatf("v%0d_ram_bad_words", v), ram_a_diff(), 0);
            check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("v%0d_wr_latency_bad", v), wr_lat_bad, 0);
            check($sformatf("v%0d_reads", v), rd_cnt, 16);
            check($sformatf("v%0d_idle_busy", v), int'(busy_a), 0);
        end

        // Abort during the write-back of address 2; address 9 also corrupted.
        begin
            logic [15:0][6:0] err;
            err = '0; err[2] = 7'h02; err[9] = 7'h20;
            load_a(err);
            clear_mon();
            pulse_start_a();
            found = 0;
            for (int n = 0; n < 100 && found == 0; n++) begin
                @(negedge clk);
                if (bus_a.mem_wr_en && bus_a.mem_addr == 4'd2) found = 1;
            end
            check("abort_write_seen", found, 1);
            abort_a = 1'b1;
            @(negedge clk);
            abort_a = 1'b0;
            check("abort_idle_next", int'(busy_a), 0);
            check("abort_write_landed", int'(ram_a[2]), int'(golden[2]));
            repeat (20) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            check("abort_corr", int'(corr_a), 1);
            check("abort_last_addr", int'(lea_a), 2);
            check("abort_addr9_untouched", int'(ram_a[9]), int'(golden[9] ^ 7'h20));
            check("abort_writes", wr_cnt, 1);
            check("abort_stays_idle", int'(busy_a), 0);
        end

        // Start re-pulsed mid-scan, then reset while reading address 7.
        begin
            logic [15:0][6:0] err;
            err = '0; err[3] = 7'h01;
            load_a(err);
            clear_mon();
            pulse_start_a();
            found = 0;
            for (int n = 0; n < 100 && found == 0; n++) begin
                @(negedge clk);
                if (bus_a.mem_rd_en && bus_a.mem_addr == 4'd5) found = 1;
            end
            check("restart_addr5_seen", found, 1);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            found = 0;
            for (int n = 0; n < 100 && found == 0; n++) begin
                if (bus_a.mem_rd_en && bus_a.mem_addr == 4'd7) found = 1;
                else @(negedge clk);
            end
            check("restart_addr7_seen", found, 1);
            check("restart_no_clear", int'(corr_a), 1);
            check("restart_last_addr", int'(lea_a), 3);
            check("restart_no_restart", rd0_cnt, 1);
            check("restart_busy", int'(busy_a), 1);
            rst_n = 1'b0;
            @(negedge clk);
            check("midrst_busy", int'(busy_a), 0);
            check("midrst_done", int'(done_a), 0);
            check("midrst_corr", int'(corr_a), 0);
            check("midrst_last_addr", int'(lea_a), 0);
            check("midrst_last_syn", int'(syn_a), 0);
            check("midrst_mem_addr", int'(bus_a.mem_addr), 0);
            check("midrst_rd_en", int'(bus_a.mem_rd_en), 0);
            check("midrst_wr_en", int'(bus_a.mem_wr_en), 0);
            check("midrst_wr_data", int'(bus_a.mem_wr_data), 0);
            rst_n = 1'b1;
            clear_mon();
            repeat (10) @(negedge clk);
            check("midrst_no_reads", rd_cnt, 0);
            check("midrst_no_writes", wr_cnt, 0);
        end

        // Narrow counter saturates; start and abort together in IDLE: start wins.
        begin
            int n;
            for (int i = 0; i < 16; i++) init_b[i] = golden[i];
            init_b[1]  = golden[1]  ^ 7'h01;
            init_b[4]  = golden[4]  ^ 7'h04;
            init_b[8]  = golden[8]  ^ 7'h08;
            init_b[12] = golden[12] ^ 7'h20;
            init_b[14] = golden[14] ^ 7'h10;
            ld_b = 1'b1;
            @(posedge clk);
            #1 ld_b = 1'b0;
            @(negedge clk);
            start_b = 1'b1; abort_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0; abort_b = 1'b0;
            check("sat_start_wins", int'(busy_b), 1);
            n = 0;
            while (!done_b && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("sat_done_seen", int'(done_b), 1);
            check("sat_corr", int'(corr_b), 3);
            check("sat_last_addr", int'(lea_b), 14);
            check("sat_last_syn", int'(syn_b), 5);
            @(negedge clk);
            check("sat_ram_bad_words", ram_b_diff(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_scrub_ctrl.md
# hamming_scrub_ctrl

Memory scrubber that walks a Hamming(7,4)-protected codeword memory, checks every word, and writes back single-bit-corrected words. It sits between a simple synchronous RAM port and the team's Hamming(7,4) decode logic, sequencing read → check → conditional write-back per address. It also keeps correction statistics for software.

## Interface
Parameters:
- ADDR_W, 4: address width; scrub range is 0 .. 2^ADDR_W-1.
- CNT_W, 8: width of the saturating correction counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a full scan; sampled only in IDLE.
- abort  in  1  terminate the scan; sampled in any busy state.
- mem_addr  out  ADDR_W  RAM address for read or write.
- mem_rd_en  out  1  RAM read strobe; data returns one cycle later.
- mem_rd_data  in  7  RAM read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  RAM write strobe.
- mem_wr_data  out  7  corrected codeword.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at normal scan completion.
- corr_count  out  CNT_W  words corrected in the current or last scan; saturating.
- last_err_addr  out  ADDR_W  address of the most recent corrected word.
- last_syndrome  out  3  syndrome of the most recent corrected word.

## Operation
- Codeword layout: bit i holds Hamming position i+1. Parity at bits 0, 1, 3; data d0..d3 at bits 2, 4, 5, 6.
- Syndrome bits:
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s3 = b3^b4^b5^b6
- Syndrome S = {s3,s2,s1}. If S != 0, the corrected word is the captured word with bit S-1 inverted. Parity bits are corrected too.
- FSM states: IDLE, READ, CAPTURE, CHECK, WRITE, ADV, DONE.
  - IDLE: on start=1, clear corr_count, last_err_addr and last_syndrome, set addr=0, go to READ. Otherwise stay.
  - READ: mem_rd_en=1, mem_addr=addr. Go to CAPTURE.
  - CAPTURE: word_q <= mem_rd_data. Go to CHECK.
  - CHECK: compute S from word_q. If S != 0: corr_count++ (saturating at 2^CNT_W-1), last_err_addr<=addr, last_syndrome<=S, go to WRITE. If S == 0, go to ADV.
  - WRITE: mem_wr_en=1, mem_addr=addr, mem_wr_data=corrected word. Go to ADV.
  - ADV: if addr == 2^ADDR_W-1, go to DONE. Otherwise addr++ and go to READ.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Output decoding:
  - mem_rd_en, mem_wr_en, busy and done are decoded from the current state only (Moore).
  - busy=1 in READ, CAPTURE, CHECK, WRITE and ADV. busy=0 in IDLE and DONE.
  - mem_addr=addr in all states. mem_wr_data is registered and holds its last value outside WRITE.
- abort=1 in any busy state forces next state IDLE, with no done pulse.
  - Counters and last_* keep their values.
  - If abort is sampled in WRITE, that cycle's write still completes.
  - abort in IDLE or DONE is ignored. DONE still proceeds to IDLE with done=1.
- start while busy or in DONE is ignored. start and abort together in IDLE: start wins.
- The block is not a full SEC-DED. Double-bit errors miscorrect silently, and that is the intended behaviour.

## Timing
- Reset (rst_n=0 at an edge) gives state=IDLE and zeroes every output, addr and word_q.
  - Reset mid-scan takes effect at that edge. No further RAM strobes follow.
- Start sampled at edge T: READ for addr 0 is the cycle after T.
- Per word: 4 cycles if clean, 5 if corrected.
- Full scan: DONE is entered 4·2^ADDR_W + W cycles after the first READ cycle, where W is the number of corrected words.
- Write-back occurs 3 cycles after the word's READ cycle.
- RAM read latency is fixed at 1 cycle. mem_rd_data is sampled only in CAPTURE.
- Counter and last_* updates become visible the cycle after CHECK, i.e. coincident with WRITE.

## Test plan
- Clean RAM (all 16 words valid codewords), start pulse:
  - no mem_wr_en ever;
  - done exactly 64 cycles after the first READ;
  - corr_count=0;
  - RAM unchanged.
- Word 5 = valid codeword with bit 2 flipped (S=3):
  - single write at addr 5 restoring the original word;
  - corr_count=1, last_err_addr=5, last_syndrome=3;
  - done 65 cycles after the first READ.
- Seven words with bit i flipped (i=0..6) at addrs 0..6:
  - seven writes;
  - each writes back the original word;
  - last_syndrome=7, last_err_addr=6, corr_count=7.
- abort asserted in the WRITE of addr 2 (errors at addrs 2 and 9):
  - the addr-2 write completes;
  - IDLE next cycle;
  - no done pulse;
  - corr_count=1;
  - addr 9 untouched.
- start re-pulsed mid-scan:
  - ignored, with no restart and no counter clear;
  - rst_n=0 at addr 7 returns every output to 0 the next cycle, with no RAM strobe afterward.
- CNT_W=2 with 5 corrupted words: corr_count saturates at 3.
